// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Groups the byte-source handshake and the transmitter handshake of the UART
// TX arbiter into one bundle.
//
//   req          NUM_REQ            level request per byte source
//   req_data     NUM_REQ*DATA_BITS  source i's byte at [i*DATA_BITS +: DATA_BITS]
//   ack          NUM_REQ            one-hot completion pulse back to the winner
//   txd_startH   1                  one-cycle start strobe to the TX state machine
//   tx_data      DATA_BITS          latched byte for the TSR load
//   txd_done     1                  completion from the transmitter
//   busy         1                  arbiter is not idle
//   grant_id     clog2(NUM_REQ)     current or last granted source
//   timeout_err  1                  one-cycle pulse on watchdog abort
//
// Modports:
//   master - the arbiter (drives ack, strobes, latched data and status)
//   slave  - the surroundings (sources and transmitter)
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*DATA_BITS-1:0] req_data;
   logic [NUM_REQ-1:0]           ack;
   logic                         txd_startH;
   logic [DATA_BITS-1:0]         tx_data;
   logic                         txd_done;
   logic                         busy;
   logic [ID_W-1:0]              grant_id;
   logic                         timeout_err;

   modport master (
      input  req, req_data, txd_done,
      output ack, txd_startH, tx_data, busy, grant_id, timeout_err
   );

   modport slave (
      output req, req_data, txd_done,
      input  ack, txd_startH, tx_data, busy, grant_id, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// In IDLE the first requesting source at or above the rotating pointer wins;
// its byte and index are latched, the transmitter gets a one-cycle start
// strobe, and the arbiter waits in BUSY for txd_done. Completion returns a
// one-cycle ack to the winner; a watchdog aborts with timeout_err if the
// transmitter never finishes. A GAP cycle follows every transfer so the acked
// source can drop its request before the next arbitration.
//
// Ports:
//   bclk  - bit clock, all logic on the rising edge
//   rst   - synchronous, active-high reset
//   bus   - uart_tx_arbiter_if.master (request/data/ack and transmitter
//           handshake, see the interface file)
//
// Parameters:
//   NUM_REQ   - number of sources, power of two, 2..8
//   DATA_BITS - byte width, equal to the transmitter's data width
//   TIMEOUT   - maximum bclk cycles spent in BUSY before abort, >= 16
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8,
   parameter int TIMEOUT   = 256
) (
   input  logic              bclk,
   input  logic              rst,
   uart_tx_arbiter_if.master bus
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t               state_q;
   state_t               state_d;

   logic [ID_W-1:0]      ptr_q;
   logic [ID_W-1:0]      grant_id_q;
   logic [DATA_BITS-1:0] tx_data_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic                 timeout_err_q;
   logic [CNT_W-1:0]     wdog_q;

   logic [ID_W-1:0]      winner;
   logic [ID_W-1:0]      scan_idx;
   logic                 any_req;
   logic                 timeout_hit;
   logic                 start_strobe;
   logic                 busy_flag;

   // ---------------------------------------------------------------------------
   // Round-robin winner: first set request searching upward from ptr_q.
   // Scanning from the farthest offset down lets the nearest hit overwrite
   // the others, so the last assignment is the highest-priority one. Index
   // arithmetic wraps naturally because NUM_REQ is a power of two.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      winner   = ptr_q;
      any_req  = 1'b0;
      scan_idx = ptr_q;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan_idx = ptr_q + ID_W'(k);
         if (bus.req[scan_idx]) begin
            winner  = scan_idx;
            any_req = 1'b1;
         end
      end
   end

   // Watchdog fires on the BUSY cycle whose count has reached TIMEOUT-1.
   assign timeout_hit = (wdog_q == CNT_W'(TIMEOUT - 1));

   // ---------------------------------------------------------------------------
   // FSM state register.
   // ---------------------------------------------------------------------------
   always_ff @(posedge bclk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and state-decoded outputs.
   // txd_done only matters in BUSY; it is ignored in every other state.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      start_strobe = 1'b0;
      busy_flag    = 1'b1;
      case (state_q)
         IDLE: begin
            busy_flag = 1'b0;
            if (any_req) begin
               state_d = START;
            end
         end
         START: begin
            start_strobe = 1'b1;
            state_d      = BUSY;
         end
         BUSY: begin
            if (bus.txd_done || timeout_hit) begin
               state_d = GAP;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Grant latch, pointer, watchdog and registered pulses.
   // ack and timeout_err default low every cycle, giving one-cycle pulses.
   // Completion is tested before the watchdog, so a txd_done on the timeout
   // cycle acks and never raises timeout_err.
   // ---------------------------------------------------------------------------
   always_ff @(posedge bclk) begin
      if (rst) begin
         ptr_q         <= '0;
         grant_id_q    <= '0;
         tx_data_q     <= '0;
         ack_q         <= '0;
         timeout_err_q <= 1'b0;
         wdog_q        <= '0;
      end else begin
         ack_q         <= '0;
         timeout_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_id_q <= winner;
                  tx_data_q  <= bus.req_data[int'(winner) * DATA_BITS +: DATA_BITS];
               end
            end
            START: begin
               wdog_q <= '0;
            end
            BUSY: begin
               if (bus.txd_done) begin
                  ack_q <= NUM_REQ'(1) << grant_id_q;
                  ptr_q <= grant_id_q + ID_W'(1);
               end else if (timeout_hit) begin
                  timeout_err_q <= 1'b1;
                  ptr_q         <= grant_id_q + ID_W'(1);
               end else if (wdog_q != '1) begin
                  // Saturating count: it never wraps back to zero.
                  wdog_q <= wdog_q + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output drive.
   // ---------------------------------------------------------------------------
   assign bus.txd_startH  = start_strobe;
   assign bus.busy        = busy_flag;
   assign bus.grant_id    = grant_id_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.ack         = ack_q;
   assign bus.timeout_err = timeout_err_q;

   // ---------------------------------------------------------------------------
   // Invariants of the completion pulses.
   // ---------------------------------------------------------------------------
   a_ack_onehot : assert property (@(posedge bclk) disable iff (rst)
      $onehot0(ack_q));

   a_ack_xor_timeout : assert property (@(posedge bclk) disable iff (rst)
      !((ack_q != '0) && timeout_err_q));

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte sources. It latches the winning requester's byte, issues a one-cycle `txd_startH` to the transmitter state machine, and waits for `txd_done`. It then returns a one-cycle `ack` to the requester that won. A watchdog aborts a transfer if the transmitter never reports completion. The block sits between the host-side byte producers and the UART TX state machine / TSR datapath, in the `bclk` domain.

## Interface
- `NUM_REQ`, 4: number of requesters; power of two, 2..8.
- `DATA_BITS`, 8: byte width; must equal the transmitter's data width.
- `TIMEOUT`, 256: maximum `bclk` cycles spent in BUSY before abort; ≥ 16.
- `bclk`  in  1  bit clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_REQ  level request per source; must be held until `ack` or `timeout_err`.
- `req_data`  in  NUM_REQ*DATA_BITS  source i's byte at `[i*DATA_BITS +: DATA_BITS]`; sampled only at grant.
- `ack`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `txd_startH`  out  1  start strobe to the transmitter; exactly one cycle per transfer.
- `tx_data`  out  DATA_BITS  latched byte for TSR load; stable from grant until the next grant.
- `txd_done`  in  1  completion from the transmitter.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  log2(NUM_REQ)  index of the current or last granted source.
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, START, BUSY, GAP; 2-bit state register.
- IDLE: if any `req` bit is high, select the winner and go to START.
  - Winner is the first set bit searching upward from `ptr` (mod NUM_REQ).
  - Latch the winner's byte into `tx_data` and its index into `grant_id`.
- START: `txd_startH`=1 for this single cycle; watchdog counter cleared; go to BUSY.
- BUSY:
  - `txd_done`=1 → register `ack[grant_id]`=1; `ptr` ← `grant_id`+1 (wraps); go to GAP.
  - Otherwise, counter increments. When the counter reaches TIMEOUT-1 without `txd_done`, `timeout_err`=1, no `ack`, `ptr` advances as above, go to GAP.
- GAP: one idle cycle so the acked source can drop `req`; go to IDLE.
- `txd_done` is ignored in IDLE, START and GAP.
- If the granted source drops `req` during START/BUSY, the transfer continues and `ack` is still issued.
- Requests arriving during a transfer wait. No source may be granted twice in a row while another source is requesting.
- Watchdog counter is `clog2(TIMEOUT)` bits wide and saturates; it never wraps.

## Timing
- Reset, synchronous: state=IDLE, `ptr`=0, `grant_id`=0, `tx_data`=0, `ack`=0, `txd_startH`=0, `busy`=0, `timeout_err`=0, counter=0. Reset mid-transfer aborts silently: no `ack`, no `timeout_err`.
- `txd_startH` and `busy` are decoded from the state register. `ack` and `timeout_err` are registered.
- Request to start: `req` sampled high at edge n in IDLE → `grant_id`/`tx_data` valid and `txd_startH`=1 during cycle n..n+1 → BUSY from edge n+1.
- Done to ack: `txd_done` sampled high at edge m → `ack` high during m..m+1 (GAP) → IDLE at m+1.
- Back-to-back: next grant earliest at edge m+2, so `txd_startH` pulses are ≥ 3 cycles + transmitter time apart.
- Same-edge `txd_done` and timeout: done wins; `ack` only, no `timeout_err`.
- `ack` and `timeout_err` are never high in the same cycle.

## Test plan
- Reset with `req`=4'b1111 held: all outputs 0 while `rst`=1. After release, first grant is `grant_id`=0, `txd_startH` one cycle later than the grant edge.
- Single source: `req`=4'b0100, byte 0xA5 at index 2. Check `tx_data`=0xA5, one `txd_startH`. Drive `txd_done` 10 cycles later → `ack`=4'b0100 for exactly one cycle, `busy` low 2 cycles after `txd_done`.
- Round robin: all four held high, each `txd_done` returned after 5 cycles. Grant order must be 0,1,2,3,0; each `ack` one-hot matches `grant_id`.
- Timeout: `TIMEOUT`=16, no `txd_done` → `timeout_err` pulse 16 cycles after BUSY entry, no `ack`, next grant goes to `grant_id`+1.
- Race: `txd_done` on the exact timeout cycle → `ack` only. `txd_done` pulsed in IDLE → no effect, `ack` stays 0.
- Mid-transfer `rst` in BUSY → next cycle IDLE with all outputs 0 and `ptr`=0. A stray `txd_done` afterwards produces no `ack`.
